// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction sequencer and the opcode decoder.
//   - Opcode constants (ADD..JMP) and the decoder no-op code OP_NOP.
//   - Instruction word geometry: INSTR_W, IMM_W, OPC_W.
//   - Sequencer FSM state encoding. ST_HALT exists only when SEQ_HALT_DETECT_EN is defined.
//   - is_illegal_op(): opcodes 4'b1000..4'b1111 are outside the decoder's instruction set.
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam int IMM_W   = 4;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] ADD    = 4'h0;
  localparam logic [OPC_W-1:0] SUB    = 4'h1;
  localparam logic [OPC_W-1:0] LDA    = 4'h2;
  localparam logic [OPC_W-1:0] STA    = 4'h3;
  localparam logic [OPC_W-1:0] LDB    = 4'h4;
  localparam logic [OPC_W-1:0] STB    = 4'h5;
  localparam logic [OPC_W-1:0] LDC    = 4'h6;
  localparam logic [OPC_W-1:0] JMP    = 4'h7;
  localparam logic [OPC_W-1:0] OP_NOP = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_EXEC
`ifdef SEQ_HALT_DETECT_EN
    , ST_HALT
`endif
  } seq_state_e;

  // The decoder implements opcodes 0..7 only; the MSB flags anything else.
  function automatic logic is_illegal_op(input logic [OPC_W-1:0] op);
    return op[OPC_W-1];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer, the program ROM and the decoder/datapath.
//   imem_req    : fetch request, held until imem_valid
//   imem_addr   : fetch address (PC_W bits)
//   imem_rdata  : fetched word {opcode, imm} (INSTR_W bits)
//   imem_valid  : fetch data valid
//   instrucao   : opcode to decoder (4 bits), OP_NOP when not issuing
//   imm         : immediate to datapath (IMM_W bits)
//   instr_valid : one-cycle issue strobe
//   exec_done   : datapath finished the issued instruction
//   a_zero      : register A == 0, meaningful with exec_done
// Modports: master = sequencer side, slave = ROM/decoder/datapath side.
interface instr_sequencer_if #(
  parameter int PC_W    = 4,
  parameter int IMM_W   = cpu_pkg::IMM_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;
  logic [3:0]         instrucao;
  logic [IMM_W-1:0]   imm;
  logic               instr_valid;
  logic               exec_done;
  logic               a_zero;

  modport master (
    output imem_req, imem_addr, instrucao, imm, instr_valid,
    input  imem_rdata, imem_valid, exec_done, a_zero
  );

  modport slave (
    input  imem_req, imem_addr, instrucao, imm, instr_valid,
    output imem_rdata, imem_valid, exec_done, a_zero
  );

endinterface

// File: rtl/instr_sequencer_pc_counter.sv
// pc_counter: program counter register for the instruction sequencer.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset, clears the PC to 0
//   load_i     : load load_val_i (has priority over inc_i)
//   inc_i      : increment by one, wrapping modulo 2^PC_W
//   load_val_i : load value (already zero-extended jump target)
//   pc_o       : current PC
module pc_counter #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = PC_W'(pc_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/issue engine in front of the opcode decoder.
// Fetches {opcode, imm} words from program memory, issues each for one cycle, waits for
// the datapath to finish, resolves JMP (taken when A == 0) and advances the PC.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   run        : 1 = execute, 0 = stop at the next instruction boundary
//   bus        : instr_sequencer_if.master (imem handshake, issue outputs, exec_done/a_zero)
//   pc         : current program counter
//   illegal_op : one-cycle pulse when an opcode 8..F is issued
//   halted     : self-jump halt flag
// Optional feature: SEQ_HALT_DETECT_EN. When defined, a taken JMP to its own address parks
// the FSM in ST_HALT until reset. When undefined, a self-jump simply refetches and halted = 0.
module instr_sequencer #(
  parameter int PC_W    = 4,
  parameter int IMM_W   = cpu_pkg::IMM_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  instr_sequencer_if.master bus,
  output logic [PC_W-1:0]   pc,
  output logic              illegal_op,
  output logic              halted
);

  import cpu_pkg::*;

  seq_state_e        state_q;
  logic              req_q;
  logic              vld_q;
  logic              ill_q;
  logic [OPC_W-1:0]  opc_q;
  logic [IMM_W-1:0]  imm_q;

  logic              pc_load;
  logic              pc_inc;
  logic [PC_W-1:0]   pc_w;
  logic [PC_W-1:0]   jmp_target;
  logic              jmp_taken;
  logic [OPC_W-1:0]  fetch_opc;
  logic [IMM_W-1:0]  fetch_imm;

  assign fetch_opc  = bus.imem_rdata[INSTR_W-1 -: OPC_W];
  assign fetch_imm  = bus.imem_rdata[IMM_W-1:0];
  assign jmp_target = PC_W'(imm_q);
  assign jmp_taken  = (opc_q == JMP) && bus.a_zero;

`ifdef SEQ_HALT_DETECT_EN
  logic halted_q;
  logic self_jump;
  assign self_jump = jmp_taken && (jmp_target == pc_w);
`endif

  // PC update happens only at instruction boundaries: after an illegal issue, or when the
  // datapath reports completion in EXEC. A taken self-jump still loads its own address.
  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (is_illegal_op(opc_q)) begin
          pc_inc = 1'b1;
        end
      end
      ST_EXEC: begin
        if (bus.exec_done) begin
          if (jmp_taken) begin
            pc_load = 1'b1;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      default: begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
      end
    endcase
  end

  pc_counter #(
    .PC_W(PC_W)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pc_load),
    .inc_i      (pc_inc),
    .load_val_i (jmp_target),
    .pc_o       (pc_w)
  );

  // Single registered FSM. instr_valid and illegal_op default low every cycle so they can
  // only ever be one-cycle pulses launched on the FETCH -> ISSUE transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
      ill_q    <= 1'b0;
      opc_q    <= OP_NOP;
      imm_q    <= '0;
`ifdef SEQ_HALT_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (bus.imem_valid) begin
            state_q <= ST_ISSUE;
            req_q   <= 1'b0;
            opc_q   <= fetch_opc;
            imm_q   <= fetch_imm;
            vld_q   <= 1'b1;
            ill_q   <= is_illegal_op(fetch_opc);
          end
        end

        ST_ISSUE: begin
          if (is_illegal_op(opc_q)) begin
            // Illegal words never reach the datapath; go straight to the next PC.
            opc_q   <= OP_NOP;
            imm_q   <= '0;
            state_q <= run ? ST_FETCH : ST_IDLE;
            req_q   <= run;
          end else begin
            state_q <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (bus.exec_done) begin
            opc_q <= OP_NOP;
            imm_q <= '0;
`ifdef SEQ_HALT_DETECT_EN
            if (self_jump) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
              req_q    <= 1'b0;
            end else
`endif
            begin
              state_q <= run ? ST_FETCH : ST_IDLE;
              req_q   <= run;
            end
          end
        end

`ifdef SEQ_HALT_DETECT_EN
        ST_HALT: begin
          // Only reset leaves HALT; run is deliberately ignored here.
          state_q <= ST_HALT;
          req_q   <= 1'b0;
        end
`endif

        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          opc_q   <= OP_NOP;
          imm_q   <= '0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_w;
  assign bus.instrucao   = opc_q;
  assign bus.imm         = imm_q;
  assign bus.instr_valid = vld_q;
  assign pc              = pc_w;
  assign illegal_op      = ill_q;
`ifdef SEQ_HALT_DETECT_EN
  assign halted          = halted_q;
`else
  assign halted          = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: ROM responder, datapath responder, scoreboard
// monitor popping expected (opcode, imm, pc) records on every issue strobe, and a directed
// main sequence walking reset, straight-line, branch, wrap/stall, illegal/run and self-jump.
module tb_instr_sequencer;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] imm;
    logic [3:0] pc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] pc;
  logic       illegal_op;
  logic       halted;

  instr_sequencer_if #(.PC_W(4), .IMM_W(4), .INSTR_W(8)) bus ();

  instr_sequencer #(.PC_W(4), .IMM_W(4), .INSTR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .bus        (bus),
    .pc         (pc),
    .illegal_op (illegal_op),
    .halted     (halted)
  );

  logic [7:0] rom [16];
  exp_t       exp_q [$];
  int         issue_cyc [$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         issue_cnt = 0;
  int         req_total = 0;
  int         req_run = 0;
  int         last_burst = 0;
  int         mem_lat = 1;
  int         exec_lat = 1;
  logic       az = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [3:0] imm, input logic [3:0] p);
    exp_t e;
    e.op = op; e.imm = imm; e.pc = p;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_issues(input int n, input int budget);
    int k = 0;
    while (issue_cnt < n && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("issue_reached", 32'(issue_cnt >= n), 1);
  endtask

  task automatic wait_req(input int budget);
    int k = 0;
    while (bus.imem_req !== 1'b1 && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("req_seen", 32'(bus.imem_req), 1);
  endtask

  // Program ROM: valid appears on request cycle index mem_lat (0-based), one-cycle pulse.
  initial begin
    int mem_cnt = 0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_valid = 1'b0;
      if (bus.imem_req === 1'b1 && rst_n) begin
        if (mem_cnt == mem_lat) begin
          bus.imem_valid = 1'b1;
          bus.imem_rdata = rom[bus.imem_addr];
          mem_cnt = 0;
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Datapath: exec_done exec_lat cycles after a legal issue, with a_zero captured at issue.
  initial begin
    int   dp_cnt = 0;
    int   dp_lat = 1;
    logic dp_busy = 1'b0;
    logic dp_az = 1'b0;
    bus.exec_done = 1'b0;
    bus.a_zero = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.exec_done = 1'b0;
      if (dp_busy) begin
        dp_cnt++;
        if (dp_cnt == dp_lat) begin
          bus.exec_done = 1'b1;
          bus.a_zero = dp_az;
          dp_busy = 1'b0;
        end
      end else if (bus.instr_valid === 1'b1 && bus.instrucao[3] === 1'b0) begin
        dp_busy = 1'b1;
        dp_cnt = 0;
        dp_lat = exec_lat;
        dp_az = az;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.imem_req === 1'b1) begin
        req_total++;
        req_run++;
      end else if (req_run != 0) begin
        last_burst = req_run;
        req_run = 0;
      end
      if (bus.instr_valid === 1'b1) begin
        issue_cnt++;
        issue_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          chk("issue_op", 32'(bus.instrucao), 32'(e.op));
          chk("issue_imm", 32'(bus.imm), 32'(e.imm));
          chk("issue_pc", 32'(pc), 32'(e.pc));
          chk("issue_illegal", 32'(illegal_op), 32'(e.op[3]));
        end
      end else if (rst_n) begin
        chk("illegal_idle", 32'(illegal_op), 0);
      end
    end
  end

  initial begin
    int base;
    int snap;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0]  = 8'h05;
    rom[1]  = 8'h23;
    rom[2]  = 8'h79;
    rom[3]  = 8'h7F;
    rom[4]  = 8'h8A;
    rom[5]  = 8'h42;
    rom[6]  = 8'h76;
    rom[9]  = 8'h72;
    rom[15] = 8'h10;

    // Reset with run held high.
    rst_n = 1'b0;
    run   = 1'b1;
    cycles(2);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_addr", 32'(bus.imem_addr), 0);
    chk("rst_instrucao", 32'(bus.instrucao), 32'hF);
    chk("rst_imm", 32'(bus.imm), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);

    // Straight line: (0,5) then (2,3), 4 cycles apart.
    push_exp(4'h0, 4'h5, 4'd0);
    push_exp(4'h2, 4'h3, 4'd1);
    rst_n = 1'b1;
    wait_issues(2, 40);
    run = 1'b0;
    cycles(4);
    chk("line_pc", 32'(pc), 2);
    chk("line_req_idle", 32'(bus.imem_req), 0);
    chk("line_spacing", 32'(issue_cyc[1] - issue_cyc[0]), 4);

    // Branch: JMP 9 taken, JMP 2 taken from 9, then JMP 9 not taken -> 3.
    az = 1'b1;
    push_exp(4'h7, 4'h9, 4'd2);
    push_exp(4'h7, 4'h2, 4'd9);
    run = 1'b1;
    wait_issues(3, 40);
    wait_req(10);
    chk("br_taken_addr", 32'(bus.imem_addr), 9);
    wait_issues(4, 40);
    az = 1'b0;
    push_exp(4'h7, 4'h9, 4'd2);
    wait_issues(5, 40);
    run = 1'b0;
    cycles(4);
    chk("br_not_taken_pc", 32'(pc), 3);
    chk("br_not_taken_addr", 32'(bus.imem_addr), 3);

    // Wrap/stall: JMP 15 taken, ROM[15] with slow fetch and slow exec, then wrap to 0.
    az = 1'b1;
    push_exp(4'h7, 4'hF, 4'd3);
    push_exp(4'h1, 4'h0, 4'd15);
    run = 1'b1;
    wait_issues(6, 40);
    mem_lat  = 2;
    exec_lat = 5;
    wait_issues(7, 40);
    run = 1'b0;
    chk("wrap_req_burst", 32'(last_burst), 3);
    cycles(8);
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_addr", 32'(bus.imem_addr), 0);
    chk("wrap_req_idle", 32'(bus.imem_req), 0);
    mem_lat  = 1;
    exec_lat = 1;

    // Illegal opcode at 4 and run dropped during EXEC of the instruction at 5.
    az = 1'b0;
    push_exp(4'h0, 4'h5, 4'd0);
    push_exp(4'h2, 4'h3, 4'd1);
    push_exp(4'h7, 4'h9, 4'd2);
    push_exp(4'h7, 4'hF, 4'd3);
    push_exp(4'h8, 4'hA, 4'd4);
    push_exp(4'h4, 4'h2, 4'd5);
    run = 1'b1;
    wait_issues(13, 80);
    cycles(1);
    run = 1'b0;
    cycles(3);
    snap = req_total;
    cycles(6);
    chk("stop_no_req", 32'(req_total - snap), 0);
    chk("stop_pc", 32'(pc), 6);
    chk("illegal_spacing", 32'(issue_cyc[12] - issue_cyc[11]), 3);

    // Self-jump at 6 with A == 0.
    az = 1'b1;
`ifdef SEQ_HALT_DETECT_EN
    push_exp(4'h7, 4'h6, 4'd6);
    run = 1'b1;
    wait_req(10);
    chk("self_addr", 32'(bus.imem_addr), 6);
    wait_issues(14, 40);
    cycles(3);
    snap = req_total;
    cycles(8);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_no_req", 32'(req_total - snap), 0);
    chk("halt_instrucao", 32'(bus.instrucao), 32'hF);
    chk("halt_pc", 32'(pc), 6);
`else
    push_exp(4'h7, 4'h6, 4'd6);
    push_exp(4'h7, 4'h6, 4'd6);
    push_exp(4'h7, 4'h6, 4'd6);
    run = 1'b1;
    wait_req(10);
    chk("self_addr", 32'(bus.imem_addr), 6);
    wait_issues(16, 60);
    run = 1'b0;
    cycles(4);
    chk("loop_halted", 32'(halted), 0);
    chk("loop_pc", 32'(pc), 6);
`endif

    // Reset clears everything (including HALT).
    rst_n = 1'b0;
    run   = 1'b0;
    cycles(2);
    chk("rst2_halted", 32'(halted), 0);
    chk("rst2_pc", 32'(pc), 0);
    chk("rst2_req", 32'(bus.imem_req), 0);
    rst_n = 1'b1;

    // Reset while the instruction at pc=1 is in EXEC: no stray strobe afterwards.
    az = 1'b0;
    base = issue_cnt;
    push_exp(4'h0, 4'h5, 4'd0);
    push_exp(4'h2, 4'h3, 4'd1);
    run = 1'b1;
    wait_issues(base + 1, 40);
    exec_lat = 20;
    wait_issues(base + 2, 40);
    cycles(3);
    chk("exec_mid_pc", 32'(pc), 1);
    rst_n = 1'b0;
    run   = 1'b0;
    cycles(2);
    chk("abort_pc", 32'(pc), 0);
    chk("abort_instrucao", 32'(bus.instrucao), 32'hF);
    chk("abort_valid", 32'(bus.instr_valid), 0);
    rst_n = 1'b1;
    cycles(30);
    chk("abort_no_strobe", 32'(issue_cnt), 32'(base + 2));
    chk("abort_req_idle", 32'(bus.imem_req), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
